r4_sample_gather: RTL and testbench
===================================

R4_SAMPLE_GATHER -- requirements
Module: r4_sample_gather

Interface
REQ-001 Parameter DW, 16, bit width of each real and imaginary sample component.
REQ-002 Parameter GW, 8, bit width of the group counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  serial sample presented.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 in_re, in_im  input  DW each  signed complex sample.
REQ-008 out_valid  output  1  four-sample group presented to the radix-4 butterfly.
REQ-009 out_ready  input  1  butterfly accepts the group this cycle.
REQ-010 out_re, out_im  output  4*DW each  group as x0 in bits [DW-1:0] up to x3 in the MSB slice.
REQ-011 out_grp  output  GW  index of the presented group, modulo 2^GW.

Function
REQ-012 The block SHALL accept a sample when in_valid and in_ready are both high (in-transfer), and present a group when out_valid and out_ready are both high (out-transfer).
REQ-013 The block SHALL gather samples in arrival order into the x0, x1, x2, x3 slots of two ping-pong banks, A and B.
REQ-014 Write state:
  - write bank pointer wb, initially A
  - write index wi, 0..3; increments per in-transfer
  - on the 4th in-transfer, wi wraps to 0, the bank is marked full and wb toggles.
REQ-015 Read state:
  - read bank pointer rb, initially A
  - out_valid = full[rb]
  - an out-transfer clears full[rb], toggles rb and increments out_grp, wrapping 2^GW-1 -> 0.
REQ-016 in_ready SHALL equal NOT full[wb]; in_ready depends only on registered state, with no combinational path from out_ready.
REQ-017 Latency: out_valid SHALL rise the cycle after the in-transfer of x3; no bypass.
REQ-018 Throughput: with out_ready held high, the block SHALL sustain one in-transfer per cycle indefinitely.
REQ-019 When an out-transfer frees bank X and an in-transfer fills bank Y≠X in the same cycle, both updates SHALL take effect.
REQ-020 When both banks are full, in_ready SHALL be 0.
  - in_valid while in_ready is 0 SHALL be ignored.
  - The first out-transfer re-enables in_ready on the following cycle.
REQ-021 out_re, out_im and out_grp SHALL hold stable while out_valid is high and out_ready is low.
REQ-022 A partial group (wi≠0) SHALL wait indefinitely; there is no timeout or flush.
REQ-023 Data SHALL pass unmodified, with no scaling or rounding.

Reset
REQ-024 On rst_n low, regardless of clk, the block SHALL force:
  - wb = rb = A and wi = 0
  - full[A] = full[B] = 0 and out_grp = 0
  - out_valid = 0 and in_ready = 1.
REQ-025 Bank data registers SHALL be exempt from reset.
REQ-026 Reset asserted mid-group SHALL discard all partial and full groups.
REQ-027 Deassertion SHALL be synchronized externally; the first in-transfer may occur on the first rising edge after rst_n goes high.

Structure
REQ-028 A shared FFT package SHALL hold the DW default, the radix constant 4 and the bank-select type.
REQ-029 The block SHALL instantiate one sub-module, r4_bank (a 4-entry complex register file with indexed write and parallel read), twice.
REQ-030 All control SHALL be local flops; no memory macros.

Verification
REQ-031 Basic group: reset, out_ready=1, feed samples 1+1j, 2+2j, 3+3j, 4+4j on consecutive cycles -> one cycle after the 4th, out_valid=1 with x0..x3 = 1..4 and out_grp=0.
REQ-032 Back-pressure: out_ready=0, stream 12 samples -> two full banks; in_ready=0 after sample 8; samples 9-12 are held off; raise out_ready -> groups 0 and 1 drain in order, then samples 9-12 form group 2.
REQ-033 Streaming: 1024 back-to-back samples with out_ready=1 -> 256 groups, no bubbles on in_ready, out_grp wraps 255 -> 0.
REQ-034 Simultaneous events: an out-transfer of bank A in the same cycle as the in-transfer of x3 into B -> next cycle out_valid=1 on B, in_ready=1, wb=A.
REQ-035 Reset mid-group: assert rst_n low after 2 samples, async between edges -> out_valid=0 and in_ready=1 immediately; the next 4 samples form group 0.
REQ-036 Stall stability: random out_ready -> the presented group never changes while out_valid=1 and out_ready=0 (assertion check).

Source files
------------

// File: rtl/r4_fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : r4_fft_pkg
//  Brief    : Shared radix-4 FFT constants and the ping-pong bank-select type.
//  Revision : 1.0 - initial release
// ============================================================================
package r4_fft_pkg;

    localparam int c_DW    = 16;
    localparam int c_RADIX = 4;
    localparam int c_IDX_W = $clog2(c_RADIX);

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_t;

    function automatic bank_sel_t other_bank(input bank_sel_t b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage
`default_nettype wire

// File: rtl/r4_bank.sv
`default_nettype none
// ============================================================================
//  Module   : r4_bank
//  Brief    : Four-entry complex register file, indexed write, parallel read.
//  Revision : 1.0 - initial release
// ============================================================================
module r4_bank
    import r4_fft_pkg::*;
#(
    parameter int DW = c_DW
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [c_IDX_W-1:0]      wr_idx,
    input  logic [DW-1:0]           wr_re,
    input  logic [DW-1:0]           wr_im,
    output logic [c_RADIX*DW-1:0]   rd_re,
    output logic [c_RADIX*DW-1:0]   rd_im
);

    // Data storage carries no reset; validity is tracked by the control flops.
    logic [DW-1:0] r_re [c_RADIX];
    logic [DW-1:0] r_im [c_RADIX];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_re[wr_idx] <= wr_re;
            r_im[wr_idx] <= wr_im;
        end
    end

    generate
        for (genvar g = 0; g < c_RADIX; g++) begin : g_slot
            assign rd_re[g*DW +: DW] = r_re[g];
            assign rd_im[g*DW +: DW] = r_im[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/r4_sample_gather.sv
`default_nettype none
// ============================================================================
//  Module   : r4_sample_gather
//  Brief    : Gathers serial complex samples into ping-pong groups of four
//             for a radix-4 butterfly.
//  Revision : 1.0 - initial release
// ============================================================================
module r4_sample_gather
    import r4_fft_pkg::*;
#(
    parameter int DW = c_DW,
    parameter int GW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_re,
    input  logic [DW-1:0]           in_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [c_RADIX*DW-1:0]   out_re,
    output logic [c_RADIX*DW-1:0]   out_im,
    output logic [GW-1:0]           out_grp
);

    bank_sel_t              r_wb;
    bank_sel_t              r_rb;
    logic [c_IDX_W-1:0]     r_wi;
    logic [1:0]             r_full;
    logic [GW-1:0]          r_grp;

    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_last;
    logic [1:0]             w_full_nxt;
    logic [c_RADIX*DW-1:0]  w_a_re;
    logic [c_RADIX*DW-1:0]  w_a_im;
    logic [c_RADIX*DW-1:0]  w_b_re;
    logic [c_RADIX*DW-1:0]  w_b_im;

    // Both handshakes come purely from registered state: no out_ready -> in_ready path.
    assign in_ready   = ~r_full[r_wb];
    assign out_valid  = r_full[r_rb];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_last     = (r_wi == c_IDX_W'(c_RADIX - 1));

    // A fill and a drain can only coincide on different banks, so both apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_out_fire) begin
            w_full_nxt[r_rb] = 1'b0;
        end
        if (w_in_fire && w_last) begin
            w_full_nxt[r_wb] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb   <= BANK_A;
            r_rb   <= BANK_A;
            r_wi   <= '0;
            r_full <= '0;
            r_grp  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_fire) begin
                r_wi <= r_wi + 1'b1;
                if (w_last) begin
                    r_wb <= other_bank(r_wb);
                end
            end
            if (w_out_fire) begin
                r_rb  <= other_bank(r_rb);
                r_grp <= r_grp + 1'b1;
            end
        end
    end

    r4_bank #(.DW(DW)) u_bank_a (
        .clk    (clk),
        .wr_en  (w_in_fire && (r_wb == BANK_A)),
        .wr_idx (r_wi),
        .wr_re  (in_re),
        .wr_im  (in_im),
        .rd_re  (w_a_re),
        .rd_im  (w_a_im)
    );

    r4_bank #(.DW(DW)) u_bank_b (
        .clk    (clk),
        .wr_en  (w_in_fire && (r_wb == BANK_B)),
        .wr_idx (r_wi),
        .wr_re  (in_re),
        .wr_im  (in_im),
        .rd_re  (w_b_re),
        .rd_im  (w_b_im)
    );

    assign out_re  = (r_rb == BANK_B) ? w_b_re : w_a_re;
    assign out_im  = (r_rb == BANK_B) ? w_b_im : w_a_im;
    assign out_grp = r_grp;

endmodule
`default_nettype wire

// File: tb/tb_r4_sample_gather.sv
`default_nettype none
// ============================================================================
//  Module   : tb_r4_sample_gather
//  Brief    : Directed self-checking bench for r4_sample_gather.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_r4_sample_gather;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_re;
    logic [63:0] out_im;
    logic [7:0]  out_grp;

    int n_checks = 0;
    int n_pass   = 0;

    r4_sample_gather #(.DW(16), .GW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_grp   (out_grp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b1;
        step();
    endtask

    int          bubbles;
    int          bad;
    int          grp_seen;
    int          n;
    int          viol;
    logic        stalled;
    logic [63:0] sv_re;
    logic [63:0] sv_im;
    logic [7:0]  sv_grp;

    initial begin
        in_re = '0;
        in_im = '0;

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_grp",   64'(out_grp),   64'd0);

        // Basic group
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_re = 16'(i); in_im = 16'(i);
            step();
            if (i == 3) chk("basic_not_early", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_re",    out_re, pack4(1, 2, 3, 4));
        chk("basic_im",    out_im, pack4(1, 2, 3, 4));
        chk("basic_grp",   64'(out_grp), 64'd0);
        chk("basic_rdy",   64'(in_ready), 64'd1);
        step();
        chk("basic_drained", 64'(out_valid), 64'd0);
        chk("basic_grp_inc", 64'(out_grp), 64'd1);

        // Back-pressure
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_re = 16'(i); in_im = 16'h0 - 16'(i);
            step();
        end
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        in_re = 16'd9; in_im = 16'h0 - 16'd9;
        step();
        step();
        chk("bp_still_blocked", 64'(in_ready), 64'd0);
        chk("bp_g0_valid", 64'(out_valid), 64'd1);
        chk("bp_g0_grp",   64'(out_grp), 64'd0);
        chk("bp_g0_re",    out_re, pack4(1, 2, 3, 4));
        chk("bp_g0_im",    out_im, pack4(-1, -2, -3, -4));
        out_ready = 1'b1;
        step();
        chk("bp_g1_valid", 64'(out_valid), 64'd1);
        chk("bp_g1_grp",   64'(out_grp), 64'd1);
        chk("bp_g1_re",    out_re, pack4(5, 6, 7, 8));
        chk("bp_reenable", 64'(in_ready), 64'd1);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);
        for (int i = 10; i <= 12; i++) begin
            in_re = 16'(i); in_im = 16'h0 - 16'(i);
            step();
        end
        in_valid = 1'b0;
        chk("bp_g2_valid", 64'(out_valid), 64'd1);
        chk("bp_g2_grp",   64'(out_grp), 64'd2);
        chk("bp_g2_re",    out_re, pack4(9, 10, 11, 12));
        chk("bp_g2_im",    out_im, pack4(-9, -10, -11, -12));
        step();
        chk("bp_final_grp", 64'(out_grp), 64'd3);

        // Streaming
        do_reset();
        out_ready = 1'b1;
        bubbles = 0; bad = 0; grp_seen = 0;
        for (int k = 0; k < 1024; k++) begin
            in_valid = 1'b1; in_re = 16'(k); in_im = 16'(k + 1000);
            if (!in_ready) bubbles++;
            step();
            if (out_valid) begin
                if (out_grp !== 8'(grp_seen)) bad++;
                if (out_re !== pack4(4*grp_seen, 4*grp_seen+1, 4*grp_seen+2, 4*grp_seen+3)) bad++;
                if (out_im !== pack4(4*grp_seen+1000, 4*grp_seen+1001, 4*grp_seen+1002, 4*grp_seen+1003)) bad++;
                grp_seen++;
            end
        end
        in_valid = 1'b0;
        step();
        chk("stream_bubbles", 64'(bubbles), 64'd0);
        chk("stream_groups",  64'(grp_seen), 64'd256);
        chk("stream_data",    64'(bad), 64'd0);
        chk("stream_wrap",    64'(out_grp), 64'd0);
        chk("stream_idle",    64'(out_valid), 64'd0);

        // Simultaneous drain of A and fill of B
        do_reset();
        out_ready = 1'b0;
        for (int i = 21; i <= 27; i++) begin
            in_valid = 1'b1; in_re = 16'(i); in_im = 16'(i);
            step();
        end
        out_ready = 1'b1;
        in_re = 16'd28; in_im = 16'd28;
        step();
        in_valid = 1'b0;
        chk("sim_valid", 64'(out_valid), 64'd1);
        chk("sim_grp",   64'(out_grp), 64'd1);
        chk("sim_re",    out_re, pack4(25, 26, 27, 28));
        chk("sim_rdy",   64'(in_ready), 64'd1);
        chk("sim_wb",    64'(dut.r_wb), 64'd0);
        step();

        // Reset mid-group
        do_reset();
        out_ready = 1'b0;
        for (int i = 41; i <= 46; i++) begin
            in_valid = 1'b1; in_re = 16'(i); in_im = 16'(i);
            step();
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_rdy",   64'(in_ready), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 51; i <= 54; i++) begin
            in_valid = 1'b1; in_re = 16'(i); in_im = 16'(i + 1);
            step();
        end
        in_valid = 1'b0;
        chk("mrst_g0_valid", 64'(out_valid), 64'd1);
        chk("mrst_g0_grp",   64'(out_grp), 64'd0);
        chk("mrst_g0_re",    out_re, pack4(51, 52, 53, 54));
        chk("mrst_g0_im",    out_im, pack4(52, 53, 54, 55));
        step();

        // Random stall stability with an in-order scoreboard
        do_reset();
        n = 0; grp_seen = 0; bad = 0; viol = 0; stalled = 1'b0;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(1) != 0);
            in_re = 16'(n); in_im = 16'(n + 7);
            if (in_valid && in_ready) n++;
            if (out_valid && out_ready) begin
                if (out_grp !== 8'(grp_seen)) bad++;
                if (out_re !== pack4(4*grp_seen, 4*grp_seen+1, 4*grp_seen+2, 4*grp_seen+3)) bad++;
                if (out_im !== pack4(4*grp_seen+7, 4*grp_seen+8, 4*grp_seen+9, 4*grp_seen+10)) bad++;
                grp_seen++;
            end
            stalled = out_valid && !out_ready;
            sv_re = out_re; sv_im = out_im; sv_grp = out_grp;
            step();
            if (stalled) begin
                if (!out_valid || out_re !== sv_re || out_im !== sv_im || out_grp !== sv_grp) viol++;
            end
        end
        in_valid = 1'b0;
        chk("stall_stable",   64'(viol), 64'd0);
        chk("stall_order",    64'(bad), 64'd0);
        chk("stall_progress", 64'(grp_seen > 10), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
